switch_crossbar: RTL and testbench
==================================

# switch_crossbar

Three-port crossbar scheduler that sits directly upstream of the output buffer stage. It accepts 32-bit words from the three input queues over valid/ready handshakes and decodes each word's destination port from bits [1:0]. A round-robin arbiter per output resolves contention, and the block drives each output port's data and write-enable as a one-cycle registered pulse. Those signals are the buffer stage's `output1..3` and `out_ram_wr1..3` inputs.

## Interface
Parameters:
- `DATA_W`, default 32: word width. Must be ≥ 2.
- `CNT_W`, default 16: width of the forward and drop counters.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `in_data1`, `in_data2`, `in_data3`  in  DATA_W  head word of each input queue.
- `in_valid1`, `in_valid2`, `in_valid3`  in  1  head word present.
- `in_ready1`, `in_ready2`, `in_ready3`  out  1  word consumed this cycle.
- `out_stall1`, `out_stall2`, `out_stall3`  in  1  downstream output k cannot accept a word; tie to 0 if unused.
- `output1`, `output2`, `output3`  out  DATA_W  forwarded word.
- `out_ram_wr1`, `out_ram_wr2`, `out_ram_wr3`  out  1  write strobe for the matching output word.
- `fwd_cnt1`, `fwd_cnt2`, `fwd_cnt3`  out  CNT_W  words forwarded to each output.
- `drop_cnt`  out  CNT_W  words discarded (only when `SWITCH_XBAR_DROP_CNT_EN` is defined).

## Operation
- Destination decode, taken from `in_dataN[1:0]`:
  - 01 → output1; 10 → output2; 11 → output3.
  - 00 → drop.
  - A word whose full value is 0 is always a drop, because downstream ignores zero data.
- Request: input N requests output k when `in_validN` is high, the word is not a drop, its destination is k, and `out_stallk` is low.
- Arbitration per output k:
  - Pointer `last_k` ∈ {1,2,3}; reset value 3, so input1 has first priority.
  - Search order is last_k+1, last_k+2, last_k+3, modulo 3.
  - The first requester in that order is granted, and `last_k` is set to the granted input.
  - With no grant, `last_k` holds.
- Each input targets at most one output per cycle, so the three arbiters never conflict.
- `in_readyN` (combinational, same cycle):
  - High when input N is granted.
  - High when `in_validN` is high and the word is a drop.
  - Low otherwise.
  - A transfer occurs when valid and ready are both high.
- Output register: on a granted transfer to k, in the next cycle `outputk` = the word, `out_ram_wrk` = 1, and `fwd_cntk` increments (wraps at 2^CNT_W).
- In any cycle without a grant for k: `out_ram_wrk` = 0 and `outputk` = 0.
- Counter update on a drop transfer: increments `drop_cnt` (saturates at all-ones).
- Stall is level-sensitive:
  - While `out_stallk` is high, no grant is issued for k and inputs targeting k see ready low.
  - A word already registered still emits its pulse.

## Timing
- Reset values when `reset_n` is low at a clock edge:
  - All `output*` = 0, `out_ram_wr*` = 0, `fwd_cnt*` = 0, `drop_cnt` = 0.
  - All `last_k` = 3.
  - `in_ready*` = 0 while `reset_n` is low (gated combinationally).
- Reset mid-operation: any word registered but not yet emitted is lost. Its `out_ram_wr` is 0 in the cycle after reset.
- Latency: handshake in cycle t → `out_ram_wrk` high in cycle t+1, for exactly one cycle per word.
- Throughput: one word per output per cycle; up to three words per cycle in total when destinations differ.
- Contention: when all three inputs target the same output, grants rotate 1→2→3→1 on consecutive cycles starting from reset.
- Same-edge events: a stall asserting in the same cycle as a request blocks the grant in that cycle.
- Counter wrap: `fwd_cntk` at all-ones plus one → 0.

## Configuration
- `SWITCH_XBAR_DROP_CNT_EN` defined:
  - `drop_cnt` port and its saturating counter are present.
  - Drop words are consumed and counted.
- Not defined:
  - `drop_cnt` port is absent.
  - Drop words are still consumed (`in_readyN` high) and are silently discarded.

## Test plan
- Reset, then input1 word 0x00000005 (destination 01) → `in_ready1` high in that cycle; next cycle `output1` = 0x5 and `out_ram_wr1` = 1; `fwd_cnt1` = 1.
- Inputs 1, 2 and 3 all hold destination-10 words for 6 cycles → `output2` carries words from inputs 1,2,3,1,2,3 on consecutive cycles; `fwd_cnt2` = 6.
- Input1 → destination 01, input2 → 10, input3 → 11 in the same cycle → all three `out_ram_wr` high in the next cycle; each `fwd_cnt` = 1.
- `out_stall3` = 1 for 4 cycles with input2 holding word 0x7 → `in_ready2` = 0 for 4 cycles; transfer in cycle 5 when stall drops, `out_ram_wr3` in cycle 6.
- Words 0x00000000 and 0x00000004 on input1 with the macro defined → both consumed, no `out_ram_wr` pulse, `drop_cnt` = 2; rebuild without the macro → same ready behaviour, no `drop_cnt` port.
- `reset_n` low during continuous traffic → next cycle all `out_ram_wr` = 0 and counters = 0; after release, input1 wins the first contention.

Source files
------------

// File: rtl/switch_crossbar.sv
// switch_crossbar: 3x3 crossbar with a round-robin arbiter per output and registered one-cycle write pulses.
// Optional feature macro: SWITCH_XBAR_DROP_CNT_EN adds the saturating drop_cnt port and counter.
module switch_crossbar #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    input  logic [DATA_W-1:0] in_data3,
    input  logic              in_valid1,
    input  logic              in_valid2,
    input  logic              in_valid3,
    output logic              in_ready1,
    output logic              in_ready2,
    output logic              in_ready3,
    input  logic              out_stall1,
    input  logic              out_stall2,
    input  logic              out_stall3,
    output logic [DATA_W-1:0] output1,
    output logic [DATA_W-1:0] output2,
    output logic [DATA_W-1:0] output3,
    output logic              out_ram_wr1,
    output logic              out_ram_wr2,
    output logic              out_ram_wr3,
`ifdef SWITCH_XBAR_DROP_CNT_EN
    output logic [CNT_W-1:0]  drop_cnt,
`endif
    output logic [CNT_W-1:0]  fwd_cnt1,
    output logic [CNT_W-1:0]  fwd_cnt2,
    output logic [CNT_W-1:0]  fwd_cnt3
);

    localparam int NP = 3;

    logic [DATA_W-1:0] in_data [NP];
    logic [NP-1:0]     in_valid;
    logic [NP-1:0]     out_stall;
    logic [NP-1:0]     in_ready;
    logic [1:0]        dest [NP];
    logic [NP-1:0]     is_drop;
    logic [NP-1:0]     req [NP];
    logic [NP-1:0]     grant [NP];
    logic [1:0]        last_q [NP];
    logic [1:0]        last_d [NP];
    logic [DATA_W-1:0] out_data_q [NP];
    logic [DATA_W-1:0] out_data_d [NP];
    logic [NP-1:0]     out_wr_q;
    logic [NP-1:0]     out_wr_d;
    logic [CNT_W-1:0]  fwd_cnt_q [NP];
    logic [CNT_W-1:0]  fwd_cnt_d [NP];

    assign in_data[0] = in_data1;
    assign in_data[1] = in_data2;
    assign in_data[2] = in_data3;
    assign in_valid   = {in_valid3, in_valid2, in_valid1};
    assign out_stall  = {out_stall3, out_stall2, out_stall1};

    // last holds the 1-based input granted most recently; the search starts just after it.
    function automatic logic [NP-1:0] rr_pick(input logic [NP-1:0] r, input logic [1:0] last);
        logic [NP-1:0] g;
        g = '0;
        case (last)
            2'd1: begin
                if (r[1])      g = 3'b010;
                else if (r[2]) g = 3'b100;
                else if (r[0]) g = 3'b001;
            end
            2'd2: begin
                if (r[2])      g = 3'b100;
                else if (r[0]) g = 3'b001;
                else if (r[1]) g = 3'b010;
            end
            default: begin
                if (r[0])      g = 3'b001;
                else if (r[1]) g = 3'b010;
                else if (r[2]) g = 3'b100;
            end
        endcase
        return g;
    endfunction

    // An all-zero word is ignored downstream, so it is discarded like destination 00.
    always_comb begin
        for (int n = 0; n < NP; n++) begin
            dest[n]    = in_data[n][1:0];
            is_drop[n] = (in_data[n] == '0) || (in_data[n][1:0] == 2'b00);
        end
    end

    always_comb begin
        for (int k = 0; k < NP; k++) begin
            req[k]    = '0;
            grant[k]  = '0;
            last_d[k] = last_q[k];
            for (int n = 0; n < NP; n++) begin
                req[k][n] = reset_n && in_valid[n] && !is_drop[n] &&
                            (dest[n] == 2'(k + 1)) && !out_stall[k];
            end
            grant[k] = rr_pick(req[k], last_q[k]);
            if (grant[k][0])      last_d[k] = 2'd1;
            else if (grant[k][1]) last_d[k] = 2'd2;
            else if (grant[k][2]) last_d[k] = 2'd3;
        end
    end

    always_comb begin
        for (int n = 0; n < NP; n++) begin
            in_ready[n] = reset_n &&
                          ((grant[0][n] || grant[1][n] || grant[2][n]) ||
                           (in_valid[n] && is_drop[n]));
        end
    end

    assign in_ready1 = in_ready[0];
    assign in_ready2 = in_ready[1];
    assign in_ready3 = in_ready[2];

    always_comb begin
        for (int k = 0; k < NP; k++) begin
            out_wr_d[k]   = |grant[k];
            out_data_d[k] = '0;
            if (grant[k][0])      out_data_d[k] = in_data[0];
            else if (grant[k][1]) out_data_d[k] = in_data[1];
            else if (grant[k][2]) out_data_d[k] = in_data[2];
            fwd_cnt_d[k]  = fwd_cnt_q[k] + CNT_W'(out_wr_d[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < NP; k++) begin
                last_q[k]     <= 2'd3;
                out_data_q[k] <= '0;
                fwd_cnt_q[k]  <= '0;
            end
            out_wr_q <= '0;
        end else begin
            for (int k = 0; k < NP; k++) begin
                last_q[k]     <= last_d[k];
                out_data_q[k] <= out_data_d[k];
                fwd_cnt_q[k]  <= fwd_cnt_d[k];
            end
            out_wr_q <= out_wr_d;
        end
    end

    assign output1     = out_data_q[0];
    assign output2     = out_data_q[1];
    assign output3     = out_data_q[2];
    assign out_ram_wr1 = out_wr_q[0];
    assign out_ram_wr2 = out_wr_q[1];
    assign out_ram_wr3 = out_wr_q[2];
    assign fwd_cnt1    = fwd_cnt_q[0];
    assign fwd_cnt2    = fwd_cnt_q[1];
    assign fwd_cnt3    = fwd_cnt_q[2];

`ifdef SWITCH_XBAR_DROP_CNT_EN
    logic [1:0]       drop_num;
    logic [CNT_W+1:0] drop_sum;
    logic [CNT_W-1:0] drop_cnt_q;
    logic [CNT_W-1:0] drop_cnt_d;

    // Several inputs may discard in the same cycle; each one counts, clamped at all-ones.
    always_comb begin
        drop_num = '0;
        for (int n = 0; n < NP; n++) begin
            if (reset_n && in_valid[n] && is_drop[n]) drop_num = drop_num + 2'd1;
        end
        drop_sum   = {2'b00, drop_cnt_q} + {{CNT_W{1'b0}}, drop_num};
        drop_cnt_d = (drop_sum[CNT_W+1:CNT_W] != 2'b00) ? '1 : drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) drop_cnt_q <= '0;
        else          drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_switch_crossbar.sv
// tb_switch_crossbar: directed and randomized checks of switch_crossbar against a behavioural model.
// Uses a narrow counter width so wrap-around is exercised quickly; honours SWITCH_XBAR_DROP_CNT_EN.
module tb_switch_crossbar;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [31:0]   in_data1, in_data2, in_data3;
    logic          in_valid1, in_valid2, in_valid3;
    logic          in_ready1, in_ready2, in_ready3;
    logic          out_stall1, out_stall2, out_stall3;
    logic [31:0]   output1, output2, output3;
    logic          out_ram_wr1, out_ram_wr2, out_ram_wr3;
    logic [CW-1:0] fwd_cnt1, fwd_cnt2, fwd_cnt3;
`ifdef SWITCH_XBAR_DROP_CNT_EN
    logic [CW-1:0] drop_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    int          m_last [1:3];
    int          m_fwd  [1:3];
    int          m_drop;
    logic [31:0] m_out  [1:3];
    bit          m_wr   [1:3];
    bit          exp_rdy [1:3];

    switch_crossbar #(.DATA_W(32), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
        .in_valid1(in_valid1), .in_valid2(in_valid2), .in_valid3(in_valid3),
        .in_ready1(in_ready1), .in_ready2(in_ready2), .in_ready3(in_ready3),
        .out_stall1(out_stall1), .out_stall2(out_stall2), .out_stall3(out_stall3),
        .output1(output1), .output2(output2), .output3(output3),
        .out_ram_wr1(out_ram_wr1), .out_ram_wr2(out_ram_wr2), .out_ram_wr3(out_ram_wr3),
`ifdef SWITCH_XBAR_DROP_CNT_EN
        .drop_cnt(drop_cnt),
`endif
        .fwd_cnt1(fwd_cnt1), .fwd_cnt2(fwd_cnt2), .fwd_cnt3(fwd_cnt3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_drop_word(input logic [31:0] w);
        return (w == 32'h0) || (w[1:0] == 2'b00);
    endfunction

    task automatic reset_model();
        for (int k = 1; k <= 3; k++) begin
            m_last[k] = 3;
            m_fwd[k]  = 0;
            m_out[k]  = '0;
            m_wr[k]   = 1'b0;
        end
        m_drop = 0;
    endtask

    task automatic check_output();
        check("output1", output1, m_out[1]);
        check("output2", output2, m_out[2]);
        check("output3", output3, m_out[3]);
        check("out_ram_wr1", {31'b0, out_ram_wr1}, {31'b0, m_wr[1]});
        check("out_ram_wr2", {31'b0, out_ram_wr2}, {31'b0, m_wr[2]});
        check("out_ram_wr3", {31'b0, out_ram_wr3}, {31'b0, m_wr[3]});
        check("fwd_cnt1", 32'(fwd_cnt1), 32'(m_fwd[1]));
        check("fwd_cnt2", 32'(fwd_cnt2), 32'(m_fwd[2]));
        check("fwd_cnt3", 32'(fwd_cnt3), 32'(m_fwd[3]));
`ifdef SWITCH_XBAR_DROP_CNT_EN
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
    endtask

    // One clock cycle: drive after a falling edge, check readies, model the edge, check registers.
    task automatic apply_stimulus(input bit rst_n, input bit [3:1] v,
                                  input logic [31:0] d1, input logic [31:0] d2,
                                  input logic [31:0] d3, input bit [3:1] st);
        logic [31:0] d [1:3];
        int          src [1:3];
        int          n;
        int          ndrop;
        d[1] = d1; d[2] = d2; d[3] = d3;
        reset_n   = rst_n;
        in_data1  = d1; in_data2 = d2; in_data3 = d3;
        in_valid1 = v[1]; in_valid2 = v[2]; in_valid3 = v[3];
        out_stall1 = st[1]; out_stall2 = st[2]; out_stall3 = st[3];
        #1;
        ndrop = 0;
        for (int k = 1; k <= 3; k++) begin
            src[k] = 0;
            if (rst_n && !st[k]) begin
                for (int i = 1; i <= 3; i++) begin
                    n = ((m_last[k] - 1 + i) % 3) + 1;
                    if (src[k] == 0 && v[n] && !is_drop_word(d[n]) && d[n][1:0] == 2'(k))
                        src[k] = n;
                end
            end
        end
        for (int i = 1; i <= 3; i++) begin
            exp_rdy[i] = rst_n && ((v[i] && is_drop_word(d[i])) ||
                                   src[1] == i || src[2] == i || src[3] == i);
            if (rst_n && v[i] && is_drop_word(d[i])) ndrop++;
        end
        check("in_ready1", {31'b0, in_ready1}, {31'b0, exp_rdy[1]});
        check("in_ready2", {31'b0, in_ready2}, {31'b0, exp_rdy[2]});
        check("in_ready3", {31'b0, in_ready3}, {31'b0, exp_rdy[3]});
        if (!rst_n) begin
            reset_model();
        end else begin
            for (int k = 1; k <= 3; k++) begin
                if (src[k] != 0) begin
                    m_out[k]  = d[src[k]];
                    m_wr[k]   = 1'b1;
                    m_fwd[k]  = (m_fwd[k] + 1) % (CMAX + 1);
                    m_last[k] = src[k];
                end else begin
                    m_out[k] = '0;
                    m_wr[k]  = 1'b0;
                end
            end
            m_drop = (m_drop + ndrop > CMAX) ? CMAX : m_drop + ndrop;
        end
        @(negedge clk);
        check_output();
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 7) == 0) r = '0;
        return r;
    endfunction

    initial begin
        logic [31:0] cur [1:3];
        bit   [3:1]  vld;
        bit   [3:1]  stl;
        logic [31:0] seq2 [6];

        seq2[0] = 32'h102; seq2[1] = 32'h202; seq2[2] = 32'h302;
        seq2[3] = 32'h102; seq2[4] = 32'h202; seq2[5] = 32'h302;
        reset_model();
        reset_n = 1'b0;
        in_data1 = '0; in_data2 = '0; in_data3 = '0;
        in_valid1 = 1'b0; in_valid2 = 1'b0; in_valid3 = 1'b0;
        out_stall1 = 1'b0; out_stall2 = 1'b0; out_stall3 = 1'b0;
        @(negedge clk);

        // Reset with inputs valid: readies gated low, all registers clear.
        apply_stimulus(1'b0, 3'b111, 32'h5, 32'h6, 32'h7, 3'b000);
        apply_stimulus(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 3'b000);

        // Single forward to output1.
        apply_stimulus(1'b1, 3'b001, 32'h5, 32'h0, 32'h0, 3'b000);
        check("t1_output1", output1, 32'h5);
        check("t1_fwd_cnt1", 32'(fwd_cnt1), 32'd1);

        // Three-way contention on output2 rotates 1,2,3,1,2,3.
        for (int c = 0; c < 6; c++) begin
            apply_stimulus(1'b1, 3'b111, 32'h102, 32'h202, 32'h302, 3'b000);
            check("rr_output2", output2, seq2[c]);
        end
        check("rr_fwd_cnt2", 32'(fwd_cnt2), 32'd6);

        // Distinct destinations all forward in one cycle.
        apply_stimulus(1'b1, 3'b111, 32'hA1, 32'hB2, 32'hC3, 3'b000);
        check("par_wr", {29'b0, out_ram_wr3, out_ram_wr2, out_ram_wr1}, 32'h7);

        // Stall on output3 holds input2 off for four cycles.
        for (int c = 0; c < 4; c++) begin
            apply_stimulus(1'b1, 3'b010, 32'h0, 32'h7, 32'h0, 3'b100);
            check("stall_wr3", {31'b0, out_ram_wr3}, 32'h0);
        end
        apply_stimulus(1'b1, 3'b010, 32'h0, 32'h7, 32'h0, 3'b000);
        check("unstall_output3", output3, 32'h7);

        // Drop words are consumed without a write pulse.
        apply_stimulus(1'b1, 3'b001, 32'h0, 32'h0, 32'h0, 3'b000);
        apply_stimulus(1'b1, 3'b001, 32'h4, 32'h0, 32'h0, 3'b000);
        check("drop_wr1", {31'b0, out_ram_wr1}, 32'h0);

        // Reset during traffic, then input1 wins the first contention.
        apply_stimulus(1'b1, 3'b111, 32'h11, 32'h21, 32'h31, 3'b000);
        apply_stimulus(1'b0, 3'b111, 32'h11, 32'h21, 32'h31, 3'b000);
        check("mid_rst_wr1", {31'b0, out_ram_wr1}, 32'h0);
        check("mid_rst_fwd1", 32'(fwd_cnt1), 32'h0);
        apply_stimulus(1'b1, 3'b111, 32'h11, 32'h21, 32'h31, 3'b000);
        check("post_rst_output1", output1, 32'h11);

        // Randomized traffic; words stay at the head until accepted.
        for (int i = 1; i <= 3; i++) begin
            cur[i] = rand_word();
            vld[i] = 1'b1;
        end
        for (int c = 0; c < 400; c++) begin
            for (int k = 1; k <= 3; k++) stl[k] = ($urandom_range(0, 4) == 0);
            apply_stimulus(($urandom_range(0, 49) != 0), vld, cur[1], cur[2], cur[3], stl);
            for (int i = 1; i <= 3; i++) begin
                if (!vld[i] || exp_rdy[i]) begin
                    vld[i] = ($urandom_range(0, 4) != 0);
                    cur[i] = rand_word();
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
